// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction-fetch stage of the 5-stage RV64 core.
// Owns the fetch PC, issues in-order word requests to instruction memory,
// tags each request with its PC, buffers returned words in a show-ahead FIFO
// and presents {pc, instr, fault} to decode over valid/ready. Redirects flush
// the FIFO and arm a drop counter that discards responses still in flight.
module riscv_fetch #(
  parameter logic [63:0] RESETVEC        = 64'h8000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam int IW        = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int SW        = ((IW > CW) ? IW : CW) + 1;
  localparam int FPW       = $clog2(FIFO_DEPTH);
  localparam int TPW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TAG_SLOTS = 1 << TPW;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  logic [63:0]   fetch_pc;
  logic [IW-1:0] inflight;
  logic [IW-1:0] inflight_nxt;
  logic [IW-1:0] drop;
  logic [SW-1:0] occupancy;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_keep;
  logic          if_pop;

  logic [CW-1:0]  fifo_count;
  logic [FPW-1:0] fifo_wr;
  logic [FPW-1:0] fifo_rd;
  fetch_entry_t   fifo_mem [FIFO_DEPTH];
  fetch_entry_t   head;

  logic [63:0]    tag_mem [TAG_SLOTS];
  logic [TPW-1:0] tag_wr;
  logic [TPW-1:0] tag_rd;

  // The low bits of the redirect target are forced to zero, so they are never read.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Issue a request only when a FIFO slot is reserved for every response in flight.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    occupancy      = SW'(inflight) + SW'(fifo_count);
    credit_ok      = (inflight < IW'(MAX_OUTSTANDING)) && (occupancy < SW'(FIFO_DEPTH));
    imem_req_valid = !reset && !redirect_valid && credit_ok;
  end

  assign imem_req_addr = fetch_pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_keep      = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign if_pop        = if_valid && if_ready;
  assign inflight_nxt  = inflight + IW'(req_fire) - IW'(imem_rsp_valid);

  // Fetch PC, outstanding-request count and stale-response drop count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      fetch_pc <= RESETVEC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[63:2], 2'b00};
        drop     <= inflight_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (imem_rsp_valid && (drop != '0)) begin
          drop <= drop - IW'(1);
        end
      end
    end
  end

  // In-order PC tag queue pointers: push on accept, pop on every response.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (req_fire) begin
        tag_wr <= tag_wr + TPW'(1);
      end
      if (imem_rsp_valid) begin
        tag_rd <= tag_rd + TPW'(1);
      end
    end
  end

  // PC tag storage, written at accept time.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are left unreset; the pointers and counts alone define which slots are live.
    if (req_fire) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
  end

  // Output FIFO control: redirect flushes, otherwise push kept responses and pop on handshake.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_keep) begin
        fifo_wr <= fifo_wr + FPW'(1);
      end
      if (if_pop) begin
        fifo_rd <= fifo_rd + FPW'(1);
      end
      fifo_count <= fifo_count + CW'(rsp_keep) - CW'(if_pop);
    end
  end

  // FIFO storage: a faulting fetch carries a zero instruction word.
  always_ff @(posedge clk) begin
    if (!reset && rsp_keep) begin
      fifo_mem[fifo_wr] <= '{pc:    tag_mem[tag_rd],
                             instr: imem_rsp_err ? 32'd0 : imem_rsp_data,
                             fault: imem_rsp_err};
    end
  end

  // Show-ahead output from the FIFO head; zeros while empty.
  assign head     = fifo_mem[fifo_rd];
  assign if_valid = (fifo_count != '0);
  assign if_pc    = if_valid ? head.pc    : 64'd0;
  assign if_instr = if_valid ? head.instr : 32'd0;
  assign if_fault = if_valid ? head.fault : 1'b0;

  a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (inflight != '0));
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (rsp_keep && !if_pop) |-> (fifo_count < CW'(FIFO_DEPTH)));
  a_fifo_no_underflow: assert property (@(posedge clk) disable iff (reset)
    if_pop |-> (fifo_count != '0));

endmodule
